// File: rtl/rx_block_lock_if.sv
// rx_block_lock_if: header stream in, slip/lock/status out, between gearbox and block-lock controller.
interface rx_block_lock_if;
    logic [1:0] i_rx_header;
    logic       i_rx_valid;
    logic       i_cnt_clear;
    logic       o_slip;
    logic       o_block_lock;
    logic [7:0] o_sh_err_cnt;
    logic [1:0] o_state;
    modport master (
        output i_rx_header, i_rx_valid, i_cnt_clear,
        input  o_slip, o_block_lock, o_sh_err_cnt, o_state
    );
    modport slave (
        input  i_rx_header, i_rx_valid, i_cnt_clear,
        output o_slip, o_block_lock, o_sh_err_cnt, o_state
    );
endinterface

// File: rtl/rx_block_lock.sv
// rx_block_lock: 64b/66b sync-header block-lock FSM; slips the gearbox until aligned, drops lock on error bursts.
module rx_block_lock #(
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 1024,
    parameter int INVALID_LIMIT = 16,
    parameter int SLIP_WAIT     = 4
) (
    input logic i_rxc,
    input logic i_reset,
    rx_block_lock_if.slave rx
);
    localparam int SHW = $clog2(LOCK_COUNT) + 1;
    localparam int WNW = $clog2(WINDOW) + 1;
    localparam int IVW = $clog2(INVALID_LIMIT) + 1;
    localparam int WTW = $clog2(SLIP_WAIT) + 1;
    localparam logic [SHW-1:0] SH_LAST  = SHW'(LOCK_COUNT - 1);
    localparam logic [WNW-1:0] WIN_LAST = WNW'(WINDOW - 1);
    localparam logic [IVW-1:0] INV_LAST = IVW'(INVALID_LIMIT - 1);
    localparam logic [WTW-1:0] WT_LAST  = WTW'(SLIP_WAIT - 1);
    typedef enum logic [1:0] {S_HUNT, S_SLIP, S_SLIP_WAIT, S_LOCKED} state_t;
    state_t         state, state_n;
    logic [SHW-1:0] sh_cnt, sh_n;
    logic [WNW-1:0] win_cnt, win_n;
    logic [IVW-1:0] inv_cnt, inv_n;
    logic [WTW-1:0] wait_cnt, wait_n;
    logic [7:0]     err_cnt, err_n;
    logic           slip, block_lock, err_inc;
    logic           qh, bad;
    assign qh  = rx.i_rx_valid;
    assign bad = qh && (rx.i_rx_header[0] == rx.i_rx_header[1]);
    always_comb begin
        state_n = state;
        sh_n    = sh_cnt;
        win_n   = win_cnt;
        inv_n   = inv_cnt;
        wait_n  = wait_cnt;
        err_inc = 1'b0;
        case (state)
            S_HUNT: if (qh) begin
                if (bad) begin
                    sh_n    = '0;
                    state_n = S_SLIP;
                end else if (sh_cnt == SH_LAST) begin
                    state_n = S_LOCKED;
                    win_n   = '0;
                    inv_n   = '0;
                end else
                    sh_n = sh_cnt + SHW'(1);
            end
            S_SLIP: begin
                state_n = S_SLIP_WAIT;
                wait_n  = '0;
            end
            S_SLIP_WAIT: if (qh) begin
                if (wait_cnt == WT_LAST) begin
                    state_n = S_HUNT;
                    sh_n    = '0;
                end else
                    wait_n = wait_cnt + WTW'(1);
            end
            S_LOCKED: if (qh) begin
                win_n   = win_cnt + WNW'(1);
                inv_n   = bad ? inv_cnt + IVW'(1) : inv_cnt;
                err_inc = bad;
                // Loss of lock takes priority over the window rollover.
                if (bad && inv_cnt == INV_LAST)
                    state_n = S_SLIP;
                else if (win_cnt == WIN_LAST) begin
                    win_n = '0;
                    inv_n = '0;
                end
            end
            default: state_n = S_HUNT;
        endcase
        err_n = rx.i_cnt_clear ? 8'd0 : (err_inc && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
    end
    always_ff @(posedge i_rxc) begin
        if (i_reset) begin
            state      <= S_HUNT;
            sh_cnt     <= '0;
            win_cnt    <= '0;
            inv_cnt    <= '0;
            wait_cnt   <= '0;
            err_cnt    <= '0;
            slip       <= 1'b0;
            block_lock <= 1'b0;
        end else begin
            state      <= state_n;
            sh_cnt     <= sh_n;
            win_cnt    <= win_n;
            inv_cnt    <= inv_n;
            wait_cnt   <= wait_n;
            err_cnt    <= err_n;
            slip       <= state_n == S_SLIP;
            block_lock <= state_n == S_LOCKED;
        end
    end
    assign rx.o_slip       = slip;
    assign rx.o_block_lock = block_lock;
    assign rx.o_sh_err_cnt = err_cnt;
    assign rx.o_state      = state;
endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock: directed block-lock scenarios; each cycle's expected {slip,lock,err,state} is queued then checked.
module tb_rx_block_lock;
    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;
    logic i_rxc = 1'b0;
    logic i_reset = 1'b1;
    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   cnt;
    rx_block_lock_if bus ();
    rx_block_lock dut (.i_rxc(i_rxc), .i_reset(i_reset), .rx(bus));
    always #5 i_rxc = ~i_rxc;
    function automatic logic [11:0] E(input int s, input int l, input int e, input int st);
        return {s[0], l[0], e[7:0], st[1:0]};
    endfunction
    task automatic step(input logic r, input logic [1:0] h, input logic v, input logic c,
                        input logic [11:0] e, input string tag);
        exp_t x;
        logic [11:0] obs;
        exp_q.push_back('{tag, e});
        i_reset = r;
        bus.i_rx_header = h;
        bus.i_rx_valid = v;
        bus.i_cnt_clear = c;
        @(posedge i_rxc);
        #1;
        x = exp_q.pop_front();
        obs = {bus.o_slip, bus.o_block_lock, bus.o_sh_err_cnt, bus.o_state};
        total++;
        assert (obs === x.exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got slip=%b lock=%b err=%0d state=%0d, want slip=%b lock=%b err=%0d state=%0d",
                   x.tag, obs[11], obs[10], obs[9:2], obs[1:0], x.exp[11], x.exp[10], x.exp[9:2], x.exp[1:0]);
        end
    endtask
    initial begin
        bus.i_rx_header = 2'b00;
        bus.i_rx_valid = 1'b0;
        bus.i_cnt_clear = 1'b0;
        step(1, 2'b00, 0, 0, E(0, 0, 0, 0), "reset");
        step(1, 2'b11, 1, 0, E(0, 0, 0, 0), "reset_qh");
        // Clean lock: exactly 64 valid headers, no slip.
        for (int i = 0; i < 64; i++)
            step(0, 2'b01, 1, 0, E(0, i == 63, 0, i == 63 ? 3 : 0), "t1_hunt");
        step(1, 2'b01, 1, 0, E(0, 0, 0, 0), "t1_reset");
        // Bad header at QH #10: one slip pulse, four discarded QHs, then 64 more for lock.
        for (int i = 0; i < 9; i++)
            step(0, 2'b01, 1, 0, E(0, 0, 0, 0), "t2_pre");
        step(0, 2'b11, 1, 0, E(1, 0, 0, 1), "t2_bad");
        step(0, 2'b01, 0, 0, E(0, 0, 0, 2), "t2_slip");
        step(0, 2'b11, 0, 0, E(0, 0, 0, 2), "t2_nonqh");
        for (int j = 0; j < 4; j++)
            step(0, 2'b11, 1, 0, E(0, 0, 0, j == 3 ? 0 : 2), "t2_wait");
        for (int i = 0; i < 64; i++)
            step(0, 2'b10, 1, 0, E(0, i == 63, 0, i == 63 ? 3 : 0), "t2_relock");
        // 15 errors in the first window, rollover, then 15 more.
        for (int i = 0; i < 15; i++)
            step(0, 2'b00, 1, 0, E(0, 1, i + 1, 3), "t3_err1");
        for (int i = 0; i < 1009; i++)
            step(0, 2'b01, 1, 0, E(0, 1, 15, 3), "t3_fill");
        for (int i = 0; i < 15; i++)
            step(0, 2'b11, 1, 0, E(0, 1, 16 + i, 3), "t3_err2");
        // 16th error in the window drops lock.
        step(0, 2'b00, 1, 0, E(1, 0, 31, 1), "t4_loss");
        step(0, 2'b01, 1, 0, E(0, 0, 31, 2), "t4_slipwait");
        for (int j = 0; j < 4; j++)
            step(0, 2'b01, 1, 0, E(0, 0, 31, j == 3 ? 0 : 2), "t4_wait");
        // Reset in SLIP_WAIT.
        step(0, 2'b00, 1, 0, E(1, 0, 31, 1), "t6_slip");
        step(0, 2'b01, 1, 0, E(0, 0, 31, 2), "t6_sw0");
        step(0, 2'b01, 1, 0, E(0, 0, 31, 2), "t6_sw1");
        step(1, 2'b00, 1, 0, E(0, 0, 0, 0), "t6_rst_wait");
        // 50% qualifier duty with garbage on unqualified cycles.
        for (int i = 0; i < 128; i++)
            if (i % 2 == 0)
                step(0, 2'b01, 1, 0, E(0, i >= 126, 0, i >= 126 ? 3 : 0), "t5_qh");
            else
                step(0, 2'b11, 0, 0, E(0, i >= 126, 0, i >= 126 ? 3 : 0), "t5_idle");
        // 17 windows of 15 errors each drive the counter to exactly 255.
        cnt = 0;
        for (int w = 0; w < 17; w++)
            for (int q = 0; q < 1024; q++) begin
                if (q < 15) cnt++;
                step(0, q < 15 ? 2'b00 : 2'b10, 1, 0, E(0, 1, cnt > 255 ? 255 : cnt, 3), "t6_fill");
            end
        step(0, 2'b00, 1, 0, E(0, 1, 255, 3), "t6_sat");
        step(0, 2'b00, 1, 1, E(0, 1, 0, 3), "t6_clr_inc");
        step(0, 2'b00, 1, 0, E(0, 1, 1, 3), "t6_inc");
        step(0, 2'b01, 1, 1, E(0, 1, 0, 3), "t6_clr");
        step(0, 2'b11, 1, 0, E(0, 1, 1, 3), "t6_inc2");
        step(1, 2'b11, 1, 0, E(0, 0, 0, 0), "t6_rst_lock");
        step(0, 2'b01, 0, 0, E(0, 0, 0, 0), "t6_post_rst");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
